// File: rtl/step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// step_ctrl_pkg
//
// Purpose:
//   Constants shared by step_ctrl and its watchdog. This package holds:
//     - the FSM state encodings,
//     - a clog2 helper that never returns zero.
//   The top level uses the helper to size its step-facing ports. Those widths
//   then match the step instance it drives.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package step_ctrl_pkg;

    // FSM state encodings. These are plain localparams so that legacy tools
    // and waveform scripts can read them.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_ABORT  = 3'd5;

    // Ceiling log2 with a floor of 1. A degenerate value can therefore never
    // produce a zero-width vector.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : step_ctrl_pkg

// File: rtl/step_ctrl_pass_timer.sv
// -----------------------------------------------------------------------------
// step_ctrl_pass_timer
//
// Purpose:
//   This is the watchdog for a single step pass.
//     - The count returns to zero while clear_i is high.
//     - The count increments while enable_i is high.
//     - The count saturates at LIMIT.
//     - expired_o is high whenever the count equals LIMIT.
//   The module body exists only when STEP_CTRL_TIMEOUT_EN is defined. The
//   default build therefore carries no counter logic at all.
//
// Parameters:
//   LIMIT      cycles until expiry
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   clear_i    in   synchronous clear (takes priority over enable)
//   enable_i   in   count enable
//   expired_o  out  count has reached LIMIT
// -----------------------------------------------------------------------------
`ifdef STEP_CTRL_TIMEOUT_EN
module step_ctrl_pass_timer
    import step_ctrl_pkg::*;
#(
    parameter  int LIMIT = 4096,
    localparam int CW    = clog2_min1(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT_C)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT_C);

endmodule : step_ctrl_pass_timer
`endif

// File: rtl/step_ctrl.sv
// -----------------------------------------------------------------------------
// step_ctrl
//
// Purpose:
//   Phase sequencer for the systolic step line. It drives a full
//   Gaussian-elimination run over an L x K matrix. Each phase p consists of:
//     - one pivot pass (functionA=1) on column block p,
//     - one update pass (functionA=0) on every column block to the right.
//   A pivot failure reported by step aborts the run.
//
// Configuration:
//   STEP_CTRL_TIMEOUT_EN  Define this macro to add a per-pass watchdog. The
//                         run aborts with fail=1 after TIMEOUT cycles in WAIT.
//
// Parameters:
//   N, L, K    line width, matrix rows, matrix columns (K % N == 0)
//   TIMEOUT    watchdog bound in cycles (effective only with the macro)
//
// Ports:
//   clk                   in   clock
//   rst                   in   asynchronous active-low reset
//   go                    in   single-cycle run request
//   busy                  out  run in progress
//   done                  out  one-cycle pulse: run completed
//   fail                  out  sticky failure flag, cleared by next accepted go
//   step_start            out  one-cycle pulse to step.start
//   step_col_block        out  column block of the current pass
//   step_functionA        out  1 = pivot pass, 0 = update pass
//   step_last_phase       out  current pass belongs to the last phase
//   step_first_pass_rows  out  col_block*L+N on pivot passes, else 0
//   step_done             in   one-cycle pulse from step.done
//   step_fail             in   step.fail, valid with step_done
// -----------------------------------------------------------------------------
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int L       = 8,
    parameter  int K       = 16,
    parameter  int TIMEOUT = 4096,
    localparam int NB      = K / N,
    localparam int PHASES  = (L + N - 1) / N,
    localparam int CBW     = clog2_min1(K / N + 1),
    localparam int RW      = clog2_min1(L * K / N + 2 * N + 1),
    localparam int PW      = clog2_min1(PHASES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic           step_start,
    output logic [CBW-1:0] step_col_block,
    output logic           step_functionA,
    output logic           step_last_phase,
    output logic [RW-1:0]  step_first_pass_rows,
    input  logic           step_done,
    input  logic           step_fail
);

    // Reject configurations that cannot be sequenced.
    if ((K % N) != 0 || TIMEOUT < 1) begin : g_bad_config
        $error("step_ctrl: K must be a multiple of N and TIMEOUT must be positive");
    end

    localparam logic [CBW-1:0] LAST_COL   = CBW'(NB - 1);
    localparam logic [PW-1:0]  LAST_PHASE = PW'(PHASES - 1);

    logic [2:0]     state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [CBW-1:0] col_q,   col_d;
    logic           func_q,  func_d;
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic           fail_q,  fail_d;
    logic           start_q, start_d;
    logic           last_q,  last_d;
    logic [RW-1:0]  rows_q,  rows_d;
    logic           load_pass;
    logic           timed_out;

`ifdef STEP_CTRL_TIMEOUT_EN
    // The watchdog restarts on every issue and counts only while the pass is
    // outstanding.
    step_ctrl_pass_timer #(
        .LIMIT     (TIMEOUT)
    ) u_pass_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == S_ISSUE),
        .enable_i  (state_q == S_WAIT),
        .expired_o (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable assigned here gets a default first. A path
        // that leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        col_d     = col_q;
        func_d    = func_q;
        busy_d    = busy_q;
        fail_d    = fail_q;
        done_d    = 1'b0;
        start_d   = 1'b0;
        last_d    = last_q;
        rows_d    = rows_q;
        load_pass = 1'b0;

        case (state_q)
            S_IDLE: begin
                // go is looked at only here. This makes go while busy a no-op.
                if (go) begin
                    state_d   = S_ISSUE;
                    phase_d   = '0;
                    col_d     = '0;
                    func_d    = 1'b1;
                    fail_d    = 1'b0;
                    busy_d    = 1'b1;
                    load_pass = 1'b1;
                end
            end

            S_ISSUE: begin
                start_d = 1'b1;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // step_fail means something only for a pivot pass, and only in
                // the step_done cycle.
                if (step_done) begin
                    state_d = (func_q && step_fail) ? S_ABORT : S_NEXT;
                end else if (timed_out) begin
                    state_d = S_ABORT;
                end
            end

            S_NEXT: begin
                if (col_q < LAST_COL) begin
                    col_d     = col_q + CBW'(1);
                    func_d    = 1'b0;
                    state_d   = S_ISSUE;
                    load_pass = 1'b1;
                end else if (phase_q < LAST_PHASE) begin
                    // The next phase pivots on the diagonal block, whose index
                    // equals the new phase number.
                    phase_d   = phase_q + PW'(1);
                    col_d     = CBW'(phase_q) + CBW'(1);
                    func_d    = 1'b1;
                    state_d   = S_ISSUE;
                    load_pass = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            S_ABORT: begin
                fail_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The derived pass outputs are updated only when a new pass is loaded.
        // They therefore stay stable from ISSUE through the step_done cycle.
        if (load_pass) begin
            last_d = (phase_d == LAST_PHASE);
            // The product is formed at full int width and narrowed only here.
            rows_d = func_d ? RW'(int'(col_d) * L + N) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples pre-edge values, whatever the statement order.
        if (!rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            col_q   <= '0;
            func_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            col_q   <= col_d;
            func_q  <= func_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            start_q <= start_d;
            last_q  <= last_d;
            rows_q  <= rows_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign fail                 = fail_q;
    assign step_start           = start_q;
    assign step_col_block       = col_q;
    assign step_functionA       = func_q;
    assign step_last_phase      = last_q;
    assign step_first_pass_rows = rows_q;

endmodule : step_ctrl

// File: tb/tb_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_ctrl
//
// Bench for step_ctrl with N=4, L=8, K=16.
//   - Inputs are driven 2 time units after each rising edge.
//   - Everything is sampled on the falling edge.
//   - A step responder answers step_done 20 cycles after each step_start.
//   - A model expresses the expected pass list and the handshake timing as
//     cycle numbers, derived from the elimination schedule.
// -----------------------------------------------------------------------------
module tb_step_ctrl;

    localparam int N      = 4;
    localparam int L      = 8;
    localparam int K      = 16;
    localparam int TMO    = 64;
    localparam int NB     = K / N;
    localparam int PHASES = (L + N - 1) / N;
    localparam int LAT    = 20;
    localparam int CBW    = $clog2(K / N + 1);
    localparam int RW     = $clog2(L * K / N + 2 * N + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           go = 1'b0;
    logic           step_done = 1'b0;
    logic           step_fail = 1'b0;
    logic           busy, done, fail, step_start, step_functionA, step_last_phase;
    logic [CBW-1:0] step_col_block;
    logic [RW-1:0]  step_first_pass_rows;

    step_ctrl #(.N(N), .L(L), .K(K), .TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .go                   (go),
        .busy                 (busy),
        .done                 (done),
        .fail                 (fail),
        .step_start           (step_start),
        .step_col_block       (step_col_block),
        .step_functionA       (step_functionA),
        .step_last_phase      (step_last_phase),
        .step_first_pass_rows (step_first_pass_rows),
        .step_done            (step_done),
        .step_fail            (step_fail)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- expected pass schedule ----------------
    typedef struct {
        int col;
        int fa;
        int last;
        int rows;
    } pass_t;

    pass_t tbl[$];

    function automatic void build_table();
        pass_t p;
        tbl = {};
        for (int ph = 0; ph < PHASES; ph++) begin
            for (int b = ph; b < NB; b++) begin
                p.col  = b;
                p.fa   = (b == ph) ? 1 : 0;
                p.last = (ph == PHASES - 1) ? 1 : 0;
                p.rows = (b == ph) ? b * L + N : 0;
                tbl.push_back(p);
            end
        end
    endfunction

    // ---------------- responder controls ----------------
    int fail_pass   = -1;   // pass index within a run that reports step_fail
    bit resp_en     = 1'b1;
    bit inject_done = 1'b0;

    initial begin
        int pend;
        int nstart;
        bit fthis;
        pend = 0;
        nstart = 0;
        fthis = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            step_done = 1'b0;
            step_fail = 1'b0;
            if (!rst) begin
                pend = 0;
                nstart = 0;
            end else begin
                if (inject_done) begin
                    step_done = 1'b1;
                    step_fail = 1'b1;
                    inject_done = 1'b0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        step_done = 1'b1;
                        step_fail = fthis;
                    end
                end
                if (step_start) begin
                    if (resp_en) begin
                        pend = LAT;
                        fthis = (nstart == fail_pass);
                    end
                    nstart++;
                end
                if (!busy) nstart = 0;
            end
        end
    end

    // ---------------- model + compare ----------------
    int cyc = 0;
    bit m_busy, m_fail, running, outstanding;
    int busy_set_at, busy_clr_at, fail_set_at, fail_clr_at;
    int exp_start_at, exp_done_at, idle_from, m_pidx, cur_start;
    int start_cnt = 0;
    int done_cnt = 0;
    int obs_col[$], obs_fa[$], obs_last[$], obs_rows[$];

    function automatic void model_reset();
        m_busy = 0; m_fail = 0; running = 0; outstanding = 0;
        busy_set_at = -1; busy_clr_at = -1; fail_set_at = -1; fail_clr_at = -1;
        exp_start_at = -1; exp_done_at = -1; idle_from = 0; m_pidx = 0; cur_start = 0;
    endfunction

    function automatic void model_abort(input int c);
        fail_set_at = c + 2;
        busy_clr_at = c + 2;
        idle_from   = c + 2;
        running     = 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            model_reset();
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_fail", 32'(fail), 0);
            check("rst_start", 32'(step_start), 0);
            check("rst_col", 32'(step_col_block), 0);
            check("rst_fa", 32'(step_functionA), 0);
            check("rst_last", 32'(step_last_phase), 0);
            check("rst_rows", 32'(step_first_pass_rows), 0);
        end else begin
            if (cyc == busy_set_at) m_busy = 1;
            if (cyc == busy_clr_at) m_busy = 0;
            if (cyc == fail_set_at) m_fail = 1;
            if (cyc == fail_clr_at) m_fail = 0;
            check("busy", 32'(busy), 32'(m_busy));
            check("fail", 32'(fail), 32'(m_fail));
            check("done", 32'(done), 32'(cyc == exp_done_at));
            check("step_start", 32'(step_start), 32'(cyc == exp_start_at));
            if (done) done_cnt++;
            if (step_start) begin
                start_cnt++;
                obs_col.push_back(int'(step_col_block));
                obs_fa.push_back(int'(step_functionA));
                obs_last.push_back(int'(step_last_phase));
                obs_rows.push_back(int'(step_first_pass_rows));
                if (running && !outstanding) begin
                    outstanding = 1;
                    cur_start = cyc;
                    m_pidx++;
                end
            end
            // Pass outputs must hold for the whole time the pass is outstanding.
            if (outstanding && m_pidx >= 1 && m_pidx <= tbl.size()) begin
                check("col_block", 32'(step_col_block), 32'(tbl[m_pidx-1].col));
                check("functionA", 32'(step_functionA), 32'(tbl[m_pidx-1].fa));
                check("last_phase", 32'(step_last_phase), 32'(tbl[m_pidx-1].last));
                check("first_rows", 32'(step_first_pass_rows), 32'(tbl[m_pidx-1].rows));
            end
            if (outstanding && step_done) begin
                outstanding = 0;
                if (tbl[m_pidx-1].fa == 1 && step_fail) begin
                    model_abort(cyc);
                end else if (m_pidx == tbl.size()) begin
                    exp_done_at = cyc + 2;
                    busy_clr_at = cyc + 2;
                    idle_from   = cyc + 3;
                    running     = 0;
                end else begin
                    exp_start_at = cyc + 3;
                end
            end
`ifdef STEP_CTRL_TIMEOUT_EN
            else if (outstanding && cyc == cur_start + TMO) begin
                outstanding = 0;
                model_abort(cyc);
            end
`endif
            if (go && !running && cyc >= idle_from) begin
                running      = 1;
                busy_set_at  = cyc + 1;
                fail_clr_at  = cyc + 1;
                exp_start_at = cyc + 2;
                m_pidx       = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_go();
        @(posedge clk); #2 go = 1'b1;
        @(posedge clk); #2 go = 1'b0;
    endtask

    task automatic wait_run_end(input string name, input int budget);
        int n;
        n = 0;
        while ((running || cyc < idle_from || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) check({name, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
    endtask

    int s0, d0;
    int exp_col[7];
    int exp_fa[7];
    int exp_last[7];
    int exp_rows[7];

    initial begin
        model_reset();
        build_table();
        exp_col  = '{0, 1, 2, 3, 1, 2, 3};
        exp_fa   = '{1, 0, 0, 0, 1, 0, 0};
        exp_last = '{0, 0, 0, 0, 1, 1, 1};
        exp_rows = '{4, 0, 0, 0, 12, 0, 0};
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: clean run, with the schedule pinned against literals
        s0 = start_cnt; d0 = done_cnt;
        obs_col = {}; obs_fa = {}; obs_last = {}; obs_rows = {};
        pulse_go();
        wait_run_end("run1", 400);
        check("run1_passes", 32'(start_cnt - s0), 7);
        check("run1_dones", 32'(done_cnt - d0), 1);
        check("run1_fail", 32'(fail), 0);
        for (int i = 0; i < 7 && i < obs_col.size(); i++) begin
            check($sformatf("seq_col%0d", i), 32'(obs_col[i]), 32'(exp_col[i]));
            check($sformatf("seq_fa%0d", i), 32'(obs_fa[i]), 32'(exp_fa[i]));
            check($sformatf("seq_last%0d", i), 32'(obs_last[i]), 32'(exp_last[i]));
            check($sformatf("seq_rows%0d", i), 32'(obs_rows[i]), 32'(exp_rows[i]));
        end

        // 2: pivot failure on phase 1 (pass index 4), then a go clears fail
        fail_pass = 4;
        s0 = start_cnt; d0 = done_cnt;
        pulse_go();
        wait_run_end("abort", 400);
        check("abort_passes", 32'(start_cnt - s0), 5);
        check("abort_dones", 32'(done_cnt - d0), 0);
        check("abort_fail", 32'(fail), 1);
        check("abort_busy", 32'(busy), 0);
        fail_pass = -1;
        pulse_go();
        @(posedge clk); #2;
        check("fail_cleared", 32'(fail), 0);
        wait_run_end("rerun", 400);

        // 3: step_fail on an update pass is ignored
        fail_pass = 2;
        d0 = done_cnt;
        pulse_go();
        wait_run_end("updfail", 400);
        check("updfail_done", 32'(done_cnt - d0), 1);
        check("updfail_fail", 32'(fail), 0);
        fail_pass = -1;

        // 4: go while busy is ignored; step_done while idle is ignored
        s0 = start_cnt; d0 = done_cnt;
        pulse_go();
        repeat (5) @(posedge clk);
        pulse_go();
        repeat (40) @(posedge clk);
        pulse_go();
        wait_run_end("gobusy", 400);
        check("gobusy_passes", 32'(start_cnt - s0), 7);
        check("gobusy_dones", 32'(done_cnt - d0), 1);
        @(posedge clk); #1 inject_done = 1'b1;
        repeat (5) @(posedge clk);
        check("spurious_busy", 32'(busy), 0);
        check("spurious_fail", 32'(fail), 0);

        // 5: asynchronous reset while WAIT
        pulse_go();
        repeat (8) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_start", 32'(step_start), 0);
        check("async_fa", 32'(step_functionA), 0);
        check("async_rows", 32'(step_first_pass_rows), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        d0 = done_cnt;
        pulse_go();
        wait_run_end("after_rst", 400);
        check("after_rst_done", 32'(done_cnt - d0), 1);

`ifdef STEP_CTRL_TIMEOUT_EN
        // 6: step never answers; the watchdog aborts the run
        resp_en = 1'b0;
        d0 = done_cnt;
        pulse_go();
        wait_run_end("tmo", 300);
        check("tmo_fail", 32'(fail), 1);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_dones", 32'(done_cnt - d0), 0);
        resp_en = 1'b1;
        pulse_go();
        wait_run_end("tmo_rerun", 400);
        check("tmo_rerun_fail", 32'(fail), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_step_ctrl

// File: doc/step_ctrl.md
# step_ctrl

Phase sequencer that sits directly upstream of the systolic `step` line and drives it through a complete Gaussian-elimination run over an L×K matrix stored in the step memory. For each phase it issues one pivot pass (functionA=1) on the diagonal column block, then one update pass (functionA=0) on every column block to its right. It handles the step start/done handshake and aborts on a pivot failure. Host software sees only go/busy/done/fail.

## Interface
- `N`, 4: systolic line width; must equal the step instance's N.
- `L`, 8: matrix rows.
- `K`, 16: matrix columns; K%N==0.
- `NB`, K/N: number of column blocks (derived, localparam).
- `PHASES`, (L+N-1)/N: number of elimination phases (derived, localparam).
- `TIMEOUT`, 4096: watchdog bound in cycles (used only with macro).

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  single-cycle run request from host.
- `busy`  out  1  high from the cycle after accepted go until done/fail.
- `done`  out  1  one-cycle pulse: run completed without failure.
- `fail`  out  1  level; set on pivot failure or timeout, cleared by next accepted go.
- `step_start`  out  1  one-cycle pulse to step.start.
- `step_col_block`  out  CLOG2(K/N+1)  column block of current pass.
- `step_functionA`  out  1  1 = pivot pass, 0 = update pass.
- `step_last_phase`  out  1  high during all passes of phase PHASES-1.
- `step_first_pass_rows`  out  CLOG2(L*K/N+2*N+1)  first-pass row bound.
- `step_done`  in  1  one-cycle pulse from step.done.
- `step_fail`  in  1  step.fail; valid in the step_done cycle.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FINISH, ABORT.
- IDLE: go=1 → ISSUE; phase=0, col_block=0, functionA=1, fail cleared.
- ISSUE: assert step_start for exactly one cycle → WAIT. Pass outputs are stable from ISSUE until the step_done cycle.
- WAIT: remain until step_done=1.
  - functionA=1 and step_fail=1 → ABORT.
  - Otherwise → NEXT.
  - step_fail is ignored on update passes.
- NEXT: if col_block < NB-1, col_block+1 with functionA=0 → ISSUE. Else, if phase < PHASES-1, phase+1 with col_block=phase+1 and functionA=1 → ISSUE. Else → FINISH.
- FINISH: pulse done → IDLE.
- ABORT: set fail → IDLE; fail holds.
- step_first_pass_rows = col_block*L + N on pivot passes, 0 on update passes. Compute in the widest width with no truncation before assignment.
- step_last_phase = (phase == PHASES-1).
- go while busy is ignored. step_done outside WAIT is ignored.
- Reset values: busy=0, done=0, fail=0, step_start=0, step_col_block=0, step_functionA=0, step_last_phase=0, step_first_pass_rows=0, state=IDLE.
- rst asserted mid-run: immediately returns to IDLE. The in-flight step pass is abandoned; host must re-go.

## Timing
- All outputs are registered.
- go at cycle t → busy=1 and state ISSUE at t+1 → step_start=1 at t+2.
- step_done at cycle u → NEXT at u+1 → next step_start at u+3.
- Last step_done at u → done=1 at u+2, busy=0 at u+2.
- Pivot failure: step_done with step_fail at u → fail=1 and busy=0 at u+2.
- Total passes per run = sum over p=0..PHASES-1 of (NB-p).

## Configuration
- `STEP_CTRL_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and resets in ISSUE.
  - Reaching TIMEOUT → ABORT with fail=1; the counter saturates.
- `STEP_CTRL_TIMEOUT_EN` undefined:
  - No counter logic is built.
  - WAIT has no exit other than step_done.

## Structure
- State encoding localparams and derived NB/PHASES go in the shared constants header alongside the CLOG2 macro, `clog2.v`, so the top level can size step ports identically.
- One sub-module, `pass_timer`: the watchdog counter with clear/enable/expired. It is instantiated only under `STEP_CTRL_TIMEOUT_EN`.

## Test plan
- N=4, L=8, K=16, step model answers done 20 cycles after start, step_fail=0:
  - Exactly 7 passes.
  - (col_block, functionA) sequence: (0,1)(1,0)(2,0)(3,0)(1,1)(2,0)(3,0).
  - last_phase=1 only on the last three passes.
  - One done pulse; fail=0.
- Same setup, first_pass_rows check: pass (0,1) → 4; pass (1,1) → 12; all update passes → 0.
- step_fail=1 on the pivot pass of phase 1:
  - fail=1 two cycles after that step_done; no further step_start; done never pulses.
  - A next go clears fail.
- step_fail=1 on an update pass: ignored; run completes with done.
- go pulsed again while busy: no effect on the sequence. Reset (rst=0) in WAIT: all outputs go to reset values asynchronously.
- With `STEP_CTRL_TIMEOUT_EN` and TIMEOUT=64, step model never returns done: fail=1 at 64 cycles after step_start plus fixed pipeline (±2); busy=0.
